spi_cfg_regs: RTL and testbench



---
 rtl/spi_cfg_pkg.sv | 26 ++
 rtl/toggle_sync.sv | 40 ++++
 rtl/spi_cfg_regs.sv | 116 +++++++++++
 tb/tb_spi_cfg_regs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Purpose: shared types and constants for the SPI configuration register block.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package spi_cfg_pkg;

   // Commit sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      TRIG   = 2'd2
   } state_t;

   localparam logic [7:0] ADDR_REG0 = 8'h00;
   localparam logic [7:0] ADDR_REG1 = 8'h01;
   localparam logic [7:0] ADDR_REG2 = 8'h02;
   localparam logic [7:0] ADDR_REG3 = 8'h03;

   localparam int DEF_TRIG_BIT    = 0;
   localparam int DEF_OVR_CLR_BIT = 7;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'h01;
   endfunction

endpackage

// File: rtl/toggle_sync.sv
// Purpose: bring the sclk-domain write toggle into iclk and turn each change into a one-cycle event.
// Latency: evt is asserted in the cycle after the SYNC_STAGES-th iclk edge following a toggle change.
// Backpressure: none; every synchronized change produces an event unless masked after reset.
//
// Ports: iclk, rst (sync, active-high) | tgl: async toggle in | evt: one-cycle change pulse.
module toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic iclk,
   input  logic rst,
   input  logic tgl,
   output logic evt
);

   localparam logic [2:0] MASK_LOAD = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ref_q;
   logic [2:0]             mask_cnt;

   // ref_q follows the synchronizer output every cycle, so while the mask
   // counter is running the edge reference is reloaded and no stale edge
   // (e.g. a toggle held high through reset) survives past the mask window.
   always_ff @(posedge iclk) begin
      if (rst) begin
         sync_q   <= '0;
         ref_q    <= 1'b0;
         mask_cnt <= MASK_LOAD;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
         ref_q  <= sync_q[SYNC_STAGES-1];
         if (mask_cnt != 3'd0) begin
            mask_cnt <= mask_cnt - 3'd1;
         end
      end
   end

   assign evt = (mask_cnt == 3'd0) && (sync_q[SYNC_STAGES-1] ^ ref_q);

endmodule

// File: rtl/spi_cfg_regs.sv
// Purpose: commit SPI write frames (addr/data) into four config registers with trigger and overrun handling.
// Latency: toggle change to register update and wr_ack = SYNC_STAGES + 2 iclk edges; trig_pulse one cycle after wr_ack.
// Backpressure: none upstream; one event may wait in a one-deep pending slot, a further event is dropped and flags overrun.
//
// Ports: iclk, rst (sync, active-high) | wr_toggle/wr_addr/wr_data: frame from serial-in stage |
//        reg0..reg3: config registers | trig_pulse, wr_ack: one-cycle pulses |
//        bad_addr_cnt: saturating out-of-range write count | overrun: sticky dropped-event flag.
module spi_cfg_regs
   import spi_cfg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TRIG_BIT    = DEF_TRIG_BIT,
   parameter int OVR_CLR_BIT = DEF_OVR_CLR_BIT
) (
   input  logic       iclk,
   input  logic       rst,
   input  logic       wr_toggle,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] reg0,
   output logic [7:0] reg1,
   output logic [7:0] reg2,
   output logic [7:0] reg3,
   output logic       trig_pulse,
   output logic       wr_ack,
   output logic [7:0] bad_addr_cnt,
   output logic       overrun
);

   localparam logic [7:0] TRIG_MASK = 8'h01 << TRIG_BIT;
   localparam logic [7:0] OVR_MASK  = 8'h01 << OVR_CLR_BIT;

   logic       wr_evt;
   state_t     state;
   logic       pending;
   logic [7:0] hold_addr;
   logic [7:0] hold_data;
   logic       overrun_set;
   logic       overrun_clr;

   toggle_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_toggle_sync (
      .iclk (iclk),
      .rst  (rst),
      .tgl  (wr_toggle),
      .evt  (wr_evt)
   );

   // An event arriving while the pending slot is occupied is lost; this
   // includes the IDLE cycle that consumes the slot, since only one frame's
   // addr/data are visible on the inputs anyway.
   assign overrun_set = wr_evt && pending;
   assign overrun_clr = (state == COMMIT) && (hold_addr == ADDR_REG0) && hold_data[OVR_CLR_BIT];

   always_ff @(posedge iclk) begin
      if (rst) begin
         state        <= IDLE;
         pending      <= 1'b0;
         hold_addr    <= 8'h00;
         hold_data    <= 8'h00;
         reg0         <= 8'h00;
         reg1         <= 8'h00;
         reg2         <= 8'h00;
         reg3         <= 8'h00;
         trig_pulse   <= 1'b0;
         wr_ack       <= 1'b0;
         bad_addr_cnt <= 8'h00;
         overrun      <= 1'b0;
      end else begin
         wr_ack     <= 1'b0;
         trig_pulse <= 1'b0;
         // Set has priority over a simultaneous clear.
         overrun    <= overrun_set || (overrun && !overrun_clr);

         case (state)
            IDLE: begin
               if (wr_evt || pending) begin
                  hold_addr <= wr_addr;
                  hold_data <= wr_data;
                  pending   <= 1'b0;
                  state     <= COMMIT;
               end
            end

            COMMIT: begin
               pending <= pending || wr_evt;
               case (hold_addr)
                  ADDR_REG0: reg0 <= hold_data & ~OVR_MASK;
                  ADDR_REG1: reg1 <= hold_data;
                  ADDR_REG2: reg2 <= hold_data;
                  ADDR_REG3: reg3 <= hold_data;
                  default:   bad_addr_cnt <= sat_inc8(bad_addr_cnt);
               endcase
               wr_ack <= (hold_addr <= ADDR_REG3);
               if ((hold_addr == ADDR_REG0) && hold_data[TRIG_BIT]) begin
                  state <= TRIG;
               end else begin
                  state <= IDLE;
               end
            end

            TRIG: begin
               pending    <= pending || wr_evt;
               trig_pulse <= 1'b1;
               // Trigger bit is self-clearing; OVR bit stays forced low.
               reg0       <= reg0 & ~TRIG_MASK & ~OVR_MASK;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Purpose: directed self-checking bench for spi_cfg_regs.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_cfg_regs;

   localparam int S = 2;

   logic       iclk;
   logic       rst;
   logic       wr_toggle;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] reg0, reg1, reg2, reg3;
   logic       trig_pulse;
   logic       wr_ack;
   logic [7:0] bad_addr_cnt;
   logic       overrun;

   int checks;
   int failures;

   spi_cfg_regs #(
      .SYNC_STAGES (S),
      .TRIG_BIT    (0),
      .OVR_CLR_BIT (7)
   ) dut (
      .iclk         (iclk),
      .rst          (rst),
      .wr_toggle    (wr_toggle),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .reg0         (reg0),
      .reg1         (reg1),
      .reg2         (reg2),
      .reg3         (reg3),
      .trig_pulse   (trig_pulse),
      .wr_ack       (wr_ack),
      .bad_addr_cnt (bad_addr_cnt),
      .overrun      (overrun)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++; if (reg0 !== 8'h00) begin failures++; $display("FAIL rst_reg0: got %h exp 00", reg0); end
      checks++; if (reg1 !== 8'h00) begin failures++; $display("FAIL rst_reg1: got %h exp 00", reg1); end
      checks++; if (reg2 !== 8'h00) begin failures++; $display("FAIL rst_reg2: got %h exp 00", reg2); end
      checks++; if (reg3 !== 8'h00) begin failures++; $display("FAIL rst_reg3: got %h exp 00", reg3); end
      checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b exp 0", wr_ack); end
      checks++; if (trig_pulse !== 1'b0) begin failures++; $display("FAIL rst_trig: got %b exp 0", trig_pulse); end
      checks++; if (bad_addr_cnt !== 8'h00) begin failures++; $display("FAIL rst_badcnt: got %h exp 00", bad_addr_cnt); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b exp 0", overrun); end
      rst = 1'b0;
      repeat (S + 3) step();
   endtask

   task automatic test_write_reg2();
      wr_addr   = 8'h02;
      wr_data   = 8'hA5;
      wr_toggle = ~wr_toggle;
      for (int k = 1; k <= S + 2; k++) begin
         step();
         if (k < S + 2) begin
            checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL w2_early_ack edge %0d: got %b exp 0", k, wr_ack); end
            checks++; if (reg2 !== 8'h00) begin failures++; $display("FAIL w2_early_reg2 edge %0d: got %h exp 00", k, reg2); end
         end else begin
            checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL w2_ack edge %0d: got %b exp 1", k, wr_ack); end
            checks++; if (reg2 !== 8'hA5) begin failures++; $display("FAIL w2_reg2: got %h exp a5", reg2); end
            checks++; if ({reg0, reg1, reg3} !== 24'h000000) begin failures++; $display("FAIL w2_others: got %h exp 000000", {reg0, reg1, reg3}); end
         end
      end
      step();
      checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL w2_ack_width: got %b exp 0", wr_ack); end
      checks++; if (reg2 !== 8'hA5) begin failures++; $display("FAIL w2_reg2_hold: got %h exp a5", reg2); end
   endtask

   task automatic test_trigger();
      wr_addr   = 8'h00;
      wr_data   = 8'h03;
      wr_toggle = ~wr_toggle;
      repeat (S + 2) step();
      checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL trig_ack: got %b exp 1", wr_ack); end
      checks++; if (reg0 !== 8'h03) begin failures++; $display("FAIL trig_reg0_commit: got %h exp 03", reg0); end
      checks++; if (trig_pulse !== 1'b0) begin failures++; $display("FAIL trig_early: got %b exp 0", trig_pulse); end
      step();
      checks++; if (trig_pulse !== 1'b1) begin failures++; $display("FAIL trig_pulse: got %b exp 1", trig_pulse); end
      checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL trig_ack_gone: got %b exp 0", wr_ack); end
      checks++; if (reg0 !== 8'h02) begin failures++; $display("FAIL trig_reg0_final: got %h exp 02", reg0); end
      step();
      checks++; if (trig_pulse !== 1'b0) begin failures++; $display("FAIL trig_width: got %b exp 0", trig_pulse); end
   endtask

   task automatic test_back_to_back();
      int acks;
      int trigs;
      acks  = 0;
      trigs = 0;
      wr_addr = 8'h01;
      wr_data = 8'h11;
      wr_toggle = ~wr_toggle;
      step();
      wr_toggle = ~wr_toggle;
      step();
      wr_toggle = ~wr_toggle;
      for (int k = 0; k < 12; k++) begin
         step();
         if (wr_ack === 1'b1) acks++;
         if (trig_pulse === 1'b1) trigs++;
      end
      checks++; if (acks !== 2) begin failures++; $display("FAIL b2b_acks: got %0d exp 2", acks); end
      checks++; if (trigs !== 0) begin failures++; $display("FAIL b2b_trigs: got %0d exp 0", trigs); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun: got %b exp 1", overrun); end
      checks++; if (reg1 !== 8'h11) begin failures++; $display("FAIL b2b_reg1: got %h exp 11", reg1); end
   endtask

   task automatic test_overrun_clear();
      wr_addr   = 8'h00;
      wr_data   = 8'h80;
      wr_toggle = ~wr_toggle;
      repeat (S + 1) step();
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_before_commit: got %b exp 1", overrun); end
      step();
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_cleared: got %b exp 0", overrun); end
      checks++; if (reg0 !== 8'h00) begin failures++; $display("FAIL ovr_reg0: got %h exp 00", reg0); end
      checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL ovr_ack: got %b exp 1", wr_ack); end
      repeat (2) step();
      checks++; if (trig_pulse !== 1'b0) begin failures++; $display("FAIL ovr_no_trig: got %b exp 0", trig_pulse); end
   endtask

   task automatic test_bad_addr();
      int acks;
      acks    = 0;
      wr_addr = 8'h3C;
      wr_data = 8'hFF;
      for (int n = 1; n <= 260; n++) begin
         wr_toggle = ~wr_toggle;
         repeat (S + 3) begin
            step();
            if (wr_ack === 1'b1) acks++;
         end
         if (n == 10) begin
            checks++; if (bad_addr_cnt !== 8'h0A) begin failures++; $display("FAIL bad_cnt_10: got %h exp 0a", bad_addr_cnt); end
         end
         if (n == 254) begin
            checks++; if (bad_addr_cnt !== 8'hFE) begin failures++; $display("FAIL bad_cnt_254: got %h exp fe", bad_addr_cnt); end
         end
         if (n == 255) begin
            checks++; if (bad_addr_cnt !== 8'hFF) begin failures++; $display("FAIL bad_cnt_255: got %h exp ff", bad_addr_cnt); end
         end
      end
      checks++; if (bad_addr_cnt !== 8'hFF) begin failures++; $display("FAIL bad_cnt_sat: got %h exp ff", bad_addr_cnt); end
      checks++; if (acks !== 0) begin failures++; $display("FAIL bad_acks: got %0d exp 0", acks); end
      checks++; if ({reg0, reg1, reg2, reg3} !== 32'h0011A500) begin failures++; $display("FAIL bad_regs: got %h exp 0011a500", {reg0, reg1, reg2, reg3}); end
   endtask

   task automatic test_reset_toggle_high();
      int acks;
      acks = 0;
      rst = 1'b1;
      step();
      wr_toggle = 1'b1;
      wr_addr   = 8'h02;
      wr_data   = 8'hFF;
      repeat (3) step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (wr_ack === 1'b1) acks++;
      end
      checks++; if (acks !== 0) begin failures++; $display("FAIL rsthi_acks: got %0d exp 0", acks); end
      checks++; if ({reg0, reg1, reg2, reg3} !== 32'h00000000) begin failures++; $display("FAIL rsthi_regs: got %h exp 00000000", {reg0, reg1, reg2, reg3}); end
      checks++; if (bad_addr_cnt !== 8'h00) begin failures++; $display("FAIL rsthi_badcnt: got %h exp 00", bad_addr_cnt); end
   endtask

   task automatic test_reset_abort();
      int bad;
      bad = 0;
      wr_addr   = 8'h00;
      wr_data   = 8'h01;
      wr_toggle = ~wr_toggle;
      repeat (S + 1) step();
      rst = 1'b1;
      step();
      checks++; if (reg0 !== 8'h00) begin failures++; $display("FAIL abort_reg0: got %h exp 00", reg0); end
      checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL abort_ack: got %b exp 0", wr_ack); end
      checks++; if (trig_pulse !== 1'b0) begin failures++; $display("FAIL abort_trig: got %b exp 0", trig_pulse); end
      checks++; if ({overrun, bad_addr_cnt} !== 9'h000) begin failures++; $display("FAIL abort_misc: got %h exp 000", {overrun, bad_addr_cnt}); end
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         if ((wr_ack === 1'b1) || (trig_pulse === 1'b1)) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL abort_after_pulses: got %0d exp 0", bad); end
      checks++; if (reg0 !== 8'h00) begin failures++; $display("FAIL abort_after_reg0: got %h exp 00", reg0); end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      wr_toggle = 1'b0;
      wr_addr   = 8'h00;
      wr_data   = 8'h00;
      test_reset();
      test_write_reg2();
      test_trigger();
      test_back_to_back();
      test_overrun_clear();
      test_bad_addr();
      test_reset_toggle_high();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
